// File: rtl/stream_pkg.sv
// stream_sink shared types and constants.
// State encoding, throttle modes and LFSR taps.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [1:0] THR_ALWAYS = 2'b00;
  localparam logic [1:0] THR_TOGGLE = 2'b01;
  localparam logic [1:0] THR_LFSR   = 2'b10;
  localparam logic [1:0] THR_STALL  = 2'b11;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stream_sink_if.sv
// Valid/ready stream bundle.
// master drives data/valid, slave drives ready.
interface stream_sink_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/stream_sink_lfsr.sv
// 16-bit Fibonacci LFSR for throttle patterns.
// Steps only when advance is high.
module stream_sink_lfsr
  import stream_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // next state: shift in feedback when advancing
  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = lfsr_next(state_q);
    end
  end

  // state register, seeded on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/stream_sink.sv
// Stream sink: throttled acceptor and sequence checker.
// Optional STREAM_SINK_PROTOCOL_CHECK_EN adds valid/data stability check.
module stream_sink
  import stream_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          CNT_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [WIDTH-1:0]     i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic                 i_enable,
  input  logic [1:0]           i_throttle_mode,
  input  logic [WIDTH-1:0]     i_start_value,
  output logic [CNT_WIDTH-1:0] o_beat_count,
  output logic [CNT_WIDTH-1:0] o_error_count,
  output logic [WIDTH-1:0]     o_first_err_data,
  output logic [WIDTH-1:0]     o_first_err_expected,
  output logic                 o_error,
  output logic                 o_protocol_error
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0]     W_ONE   = WIDTH'(1);

  stream_sink_if #(.WIDTH(WIDTH)) in_bus ();

  state_e state_q;
  state_e state_d;
  logic   ready_q;
  logic   ready_d;
  logic   load_exp;
  logic   lfsr_adv;

  logic [15:0] lfsr_state;
  logic        unused_lfsr_hi;

  logic [WIDTH-1:0]     exp_q;
  logic [WIDTH-1:0]     exp_d;
  logic [CNT_WIDTH-1:0] beat_q;
  logic [CNT_WIDTH-1:0] beat_d;
  logic [CNT_WIDTH-1:0] errc_q;
  logic [CNT_WIDTH-1:0] errc_d;
  logic [WIDTH-1:0]     fdata_q;
  logic [WIDTH-1:0]     fdata_d;
  logic [WIDTH-1:0]     fexp_q;
  logic [WIDTH-1:0]     fexp_d;
  logic                 err_q;
  logic                 err_d;

  logic hs;
  logic miss;

  assign in_bus.data  = i_in_data;
  assign in_bus.valid = i_in_valid;
  assign in_bus.ready = ready_q;
  assign o_in_ready   = in_bus.ready;

  assign hs   = in_bus.valid & in_bus.ready;
  assign miss = hs & (in_bus.data != exp_q);

  stream_sink_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock   (i_clock),
    .reset   (i_reset),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:1];

  // FSM next state, next ready and LFSR stepping
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    load_exp = 1'b0;
    lfsr_adv = 1'b0;
    unique case (state_q)
      ST_START: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_enable) begin
          load_exp = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_adv = 1'b1;
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else begin
          unique case (i_throttle_mode)
            THR_ALWAYS: ready_d = 1'b1;
            THR_TOGGLE: ready_d = ~ready_q;
            THR_LFSR:   ready_d = lfsr_state[0];
            THR_STALL:  ready_d = 1'b0;
            default:    ready_d = 1'b0;
          endcase
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // FSM state and ready registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_START;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // beat checking: counters, resync and first-error capture
  always_comb begin
    exp_d   = exp_q;
    beat_d  = beat_q;
    errc_d  = errc_q;
    fdata_d = fdata_q;
    fexp_d  = fexp_q;
    err_d   = err_q;
    if (hs) begin
      if (beat_q != CNT_MAX) begin
        beat_d = beat_q + CNT_ONE;
      end
      if (miss) begin
        exp_d = in_bus.data + W_ONE;
        err_d = 1'b1;
        if (errc_q != CNT_MAX) begin
          errc_d = errc_q + CNT_ONE;
        end
        if (!err_q) begin
          fdata_d = in_bus.data;
          fexp_d  = exp_q;
        end
      end else begin
        exp_d = exp_q + W_ONE;
      end
    end
    if (load_exp) begin
      exp_d = i_start_value;
    end
  end

  // checker registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      exp_q   <= '0;
      beat_q  <= '0;
      errc_q  <= '0;
      fdata_q <= '0;
      fexp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      beat_q  <= beat_d;
      errc_q  <= errc_d;
      fdata_q <= fdata_d;
      fexp_q  <= fexp_d;
      err_q   <= err_d;
    end
  end

  assign o_beat_count         = beat_q;
  assign o_error_count        = errc_q;
  assign o_first_err_data     = fdata_q;
  assign o_first_err_expected = fexp_q;
  assign o_error              = err_q;

`ifdef STREAM_SINK_PROTOCOL_CHECK_EN
  logic             pend_q;
  logic             pend_d;
  logic [WIDTH-1:0] pdata_q;
  logic [WIDTH-1:0] pdata_d;
  logic             perr_q;
  logic             perr_d;

  // a stalled beat must stay valid with unchanged data
  always_comb begin
    pend_d  = in_bus.valid & ~in_bus.ready;
    pdata_d = in_bus.data;
    perr_d  = perr_q;
    if (pend_q) begin
      if (!in_bus.valid || (in_bus.data != pdata_q)) begin
        perr_d = 1'b1;
      end
    end
  end

  // protocol checker registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pend_q  <= 1'b0;
      pdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      perr_q  <= perr_d;
    end
  end

  assign o_protocol_error = perr_q;
`else
  assign o_protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// Self-checking bench for stream_sink.
// Define STREAM_SINK_PROTOCOL_CHECK_EN to expect protocol flagging.
module tb_stream_sink;

  localparam int          W    = 16;
  localparam int          CW   = 32;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef STREAM_SINK_PROTOCOL_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [W-1:0]  start = '0;
  logic [CW-1:0] beats;
  logic [CW-1:0] errs;
  logic [W-1:0]  fdat;
  logic [W-1:0]  fexp;
  logic          err;
  logic          perr;

  stream_sink_if #(.WIDTH(W)) bus ();

  stream_sink #(
    .WIDTH     (W),
    .CNT_WIDTH (CW),
    .LFSR_SEED (SEED)
  ) dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_in_data            (bus.data),
    .i_in_valid           (bus.valid),
    .o_in_ready           (bus.ready),
    .i_enable             (en),
    .i_throttle_mode      (mode),
    .i_start_value        (start),
    .o_beat_count         (beats),
    .o_error_count        (errs),
    .o_first_err_data     (fdat),
    .o_first_err_expected (fexp),
    .o_error              (err),
    .o_protocol_error     (perr)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // ---- behavioural model ----
  int unsigned  m_beats = 0;
  int unsigned  m_errs  = 0;
  logic [W-1:0] m_exp   = '0;
  logic [W-1:0] m_fd    = '0;
  logic [W-1:0] m_fe    = '0;
  bit           m_err   = 1'b0;
  bit           m_prot  = 1'b0;
  bit           chk_on  = 1'b1;
`ifdef STREAM_SINK_PROTOCOL_CHECK_EN
  bit           p_pend  = 1'b0;
  logic [W-1:0] p_data  = '0;
`endif

  // ready model for an uninterrupted run
  bit          rdy_chk = 1'b0;
  bit          r_exp   = 1'b0;
  logic [15:0] r_lfsr  = SEED;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // compare outputs, then fold the coming edge into the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("beat_count", beats, 64'(m_beats));
      check("error_count", errs, 64'(m_errs));
      check("error", err, m_err);
      check("first_err_data", fdat, m_fd);
      check("first_err_expected", fexp, m_fe);
      check("protocol_error", perr, m_prot);
      if (rst) begin
        m_beats = 0;
        m_errs  = 0;
        m_fd    = '0;
        m_fe    = '0;
        m_err   = 1'b0;
        m_prot  = 1'b0;
`ifdef STREAM_SINK_PROTOCOL_CHECK_EN
        p_pend  = 1'b0;
`endif
      end else begin
`ifdef STREAM_SINK_PROTOCOL_CHECK_EN
        if (p_pend && (!bus.valid || bus.data != p_data))
          m_prot = 1'b1;
        p_pend = bus.valid && !bus.ready;
        p_data = bus.data;
`endif
        if (bus.valid && bus.ready) begin
          if (m_beats != 32'hFFFF_FFFF) m_beats++;
          if (bus.data != m_exp) begin
            if (m_errs != 32'hFFFF_FFFF) m_errs++;
            if (!m_err) begin
              m_fd = bus.data;
              m_fe = m_exp;
            end
            m_err = 1'b1;
            m_exp = bus.data + 16'd1;
          end else begin
            m_exp = m_exp + 16'd1;
          end
        end
      end
    end
  end

  // ready pattern check while a run is steady
  always @(negedge clk) begin
    if (rdy_chk) begin
      check("in_ready", bus.ready, r_exp);
      case (mode)
        2'b00:   r_exp = 1'b1;
        2'b01:   r_exp = !r_exp;
        2'b10:   r_exp = r_lfsr[0];
        default: r_exp = 1'b0;
      endcase
      r_lfsr = lfsr_step(r_lfsr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic begin_run(
    input logic [1:0]   m,
    input logic [W-1:0] s
  );
    mode  = m;
    start = s;
    en    = 1'b1;
    m_exp = s;
    tick();
    r_exp   = 1'b0;
    r_lfsr  = SEED;
    rdy_chk = 1'b1;
  endtask

  task automatic end_run();
    rdy_chk = 1'b0;
    en      = 1'b0;
    tick();
    tick();
  endtask

  task automatic send(input logic [W-1:0] w);
    bit hs;
    int guard;
    hs        = 1'b0;
    guard     = 0;
    bus.data  = w;
    bus.valid = 1'b1;
    while (!hs && guard < 200) begin
      @(negedge clk);
      hs = bus.ready;
      guard++;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      n_chk++;
      $display("FAIL send_timeout: word %0h not taken in %0d cycles",
               w, guard);
    end
  endtask

  initial begin
    bus.data  = '0;
    bus.valid = 1'b0;

    // mode 00, 100 in-order beats
    do_reset();
    check("reset_beats", beats, 0);
    check("reset_ready", bus.ready, 0);
    begin_run(2'b00, 16'h0000);
    for (int i = 0; i < 100; i++) send(W'(i));
    bus.valid = 1'b0;
    tick();
    tick();
    check("lit_100_beats", beats, 100);
    check("lit_100_errs", errs, 0);

    // handshake on the cycle enable falls still counts
    rdy_chk   = 1'b0;
    bus.data  = 16'd100;
    bus.valid = 1'b1;
    en        = 1'b0;
    @(negedge clk);
    check("ready_at_disable", bus.ready, 1);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    tick();
    check("lit_disable_beat", beats, 101);
    check("idle_ready", bus.ready, 0);

    // wrap through all-ones
    begin_run(2'b00, 16'hFFFE);
    send(16'hFFFE);
    send(16'hFFFF);
    send(16'h0000);
    bus.valid = 1'b0;
    tick();
    tick();
    check("lit_wrap_beats", beats, 104);
    check("lit_wrap_errs", errs, 0);
    check("lit_wrap_error", err, 0);
    end_run();

    // one gap: 5,6,9,10
    do_reset();
    begin_run(2'b00, 16'd5);
    send(16'd5);
    send(16'd6);
    send(16'd9);
    send(16'd10);
    bus.valid = 1'b0;
    tick();
    tick();
    check("lit_gap_beats", beats, 4);
    check("lit_gap_errs", errs, 1);
    check("lit_gap_fdata", fdat, 9);
    check("lit_gap_fexp", fexp, 7);
    check("lit_gap_error", err, 1);
    end_run();

    // mode 01, valid always high
    do_reset();
    begin_run(2'b01, 16'd0);
    cyc = 0;
    for (int i = 0; i < 8; i++) send(W'(i));
    bus.valid = 1'b0;
    check("lit_toggle_cycles", 64'(cyc), 16);
    tick();
    check("lit_toggle_beats", beats, 8);
    end_run();

    // mode 10, LFSR-paced
    do_reset();
    begin_run(2'b10, 16'd0);
    for (int i = 0; i < 6; i++) send(W'(i));
    bus.valid = 1'b0;
    tick();
    check("lit_lfsr_beats", beats, 6);
    end_run();

    // mode 11 stall with valid held, then reset
    begin_run(2'b11, 16'd0);
    bus.data  = 16'h0055;
    bus.valid = 1'b1;
    repeat (5) tick();
    check("lit_stall_beats", beats, 6);
    rdy_chk = 1'b0;
    rst     = 1'b1;
    tick();
    check("lit_rst_beats", beats, 0);
    check("lit_rst_errs", errs, 0);
    check("lit_rst_fdata", fdat, 0);
    check("lit_rst_error", err, 0);
    check("lit_rst_perr", perr, 0);
    check("lit_rst_ready", bus.ready, 0);
    bus.valid = 1'b0;
    rst       = 1'b0;
    tick();

    // reset wins over an in-flight beat
    begin_run(2'b00, 16'd0);
    tick();
    rdy_chk   = 1'b0;
    bus.data  = 16'd0;
    bus.valid = 1'b1;
    rst       = 1'b1;
    tick();
    check("lit_inflight_beats", beats, 0);
    bus.valid = 1'b0;
    rst       = 1'b0;
    tick();
    en = 1'b0;
    tick();

    // valid dropped without handshake
    do_reset();
    begin_run(2'b11, 16'd0);
    bus.data  = 16'h0033;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    tick();
    check("lit_prot_set", perr, PROT_EN);
    repeat (3) tick();
    check("lit_prot_sticky", perr, PROT_EN);
    end_run();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
